// File: rtl/recovered_frame_builder_pkg.sv
// Shared encodings and defaults for the recovered item frame builder.
// Optional SEQ byte is enabled by defining FRAME_SEQ_EN.
package recovered_frame_builder_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SYNC,
    ST_SEQ,
    ST_PAY,
    ST_CSUM
  } frame_state_t;

  localparam logic [7:0] DEF_SYNC_BYTE = 8'hA5;

  // Two's complement so that sum + checksum wraps to zero.
  function automatic logic [7:0] csum_of(input logic [7:0] sum);
    return ~sum + 8'd1;
  endfunction

endpackage

// File: rtl/recovered_frame_builder_fifo.sv
// Item FIFO for the frame builder: DEPTH x 8, pointers with a wrap bit.
// Also exposes the entry behind the head so a popping reader can prefetch.
module frame_item_fifo #(
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  logic [7:0]                 data,
  output logic [7:0]                 head,
  output logic [7:0]                 next_head,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     level
);

  localparam int AW = $clog2(DEPTH);

  logic [7:0]    mem [DEPTH];
  logic [AW:0]   wr_ptr;
  logic [AW:0]   rd_ptr;
  logic [AW-1:0] rd_nxt;
  logic          do_push;
  logic          do_pop;

  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= data;
  end

  assign rd_nxt    = rd_ptr[AW-1:0] + 1'b1;
  assign head      = mem[rd_ptr[AW-1:0]];
  assign next_head = mem[rd_nxt];
  assign level     = wr_ptr - rd_ptr;
  assign empty     = (wr_ptr == rd_ptr);
  assign full      = (wr_ptr[AW] != rd_ptr[AW]) &&
                     (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

endmodule

// File: rtl/recovered_frame_builder.sv
// Frames buffered recovered items as SYNC, [SEQ], payload, CHECKSUM bytes.
// Define FRAME_SEQ_EN to insert a rolling sequence byte after SYNC.
module recovered_frame_builder
  import recovered_frame_builder_pkg::*;
#(
  parameter int          FRAME_LEN = 4,
  parameter int          DEPTH     = 8,
  parameter logic [7:0]  SYNC_BYTE = DEF_SYNC_BYTE
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    item_valid,
  input  logic [7:0]              item_data,
  output logic                    frame_valid,
  input  logic                    frame_ready,
  output logic [7:0]              frame_data,
  output logic                    frame_sof,
  output logic                    frame_eof,
  output logic [7:0]              drop_cnt,
  output logic [$clog2(DEPTH):0]  fifo_level
);

  localparam int LW = $clog2(DEPTH) + 1;
  localparam int CW = $clog2(FRAME_LEN + 1);
  localparam logic [LW-1:0] LEN_L = LW'(FRAME_LEN);
  localparam logic [CW-1:0] LAST  = CW'(FRAME_LEN - 1);

  frame_state_t  state, state_n;
  logic          valid_n, sof_n, eof_n;
  logic [7:0]    data_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [7:0]    acc, acc_n, sum_n;
  logic          accept, push, pop;
  logic          full, empty;
  logic [7:0]    head, next_head;
`ifdef FRAME_SEQ_EN
  logic [7:0]    seq;
`endif

  assign accept = frame_valid & frame_ready;
  assign push   = item_valid & ~full;
  assign sum_n  = acc + frame_data;

  frame_item_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .pop       (pop),
    .data      (item_data),
    .head      (head),
    .next_head (next_head),
    .full      (full),
    .empty     (empty),
    .level     (fifo_level)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      frame_valid <= 1'b0;
      frame_data  <= '0;
      frame_sof   <= 1'b0;
      frame_eof   <= 1'b0;
      cnt         <= '0;
      acc         <= '0;
    end else begin
      state       <= state_n;
      frame_valid <= valid_n;
      frame_data  <= data_n;
      frame_sof   <= sof_n;
      frame_eof   <= eof_n;
      cnt         <= cnt_n;
      acc         <= acc_n;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      drop_cnt <= '0;
    end else if (item_valid && full && drop_cnt != 8'hFF) begin
      drop_cnt <= drop_cnt + 1'b1;
    end
  end

`ifdef FRAME_SEQ_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seq <= '0;
    end else if (state == ST_CSUM && accept) begin
      seq <= seq + 1'b1;
    end
  end
`endif

  // Outputs are registered, so each branch loads the byte shown next.
  always_comb begin
    state_n = state;
    valid_n = frame_valid;
    data_n  = frame_data;
    sof_n   = frame_sof;
    eof_n   = frame_eof;
    cnt_n   = cnt;
    acc_n   = acc;
    pop     = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (fifo_level >= LEN_L) begin
          state_n = ST_SYNC;
          valid_n = 1'b1;
          data_n  = SYNC_BYTE;
          sof_n   = 1'b1;
        end
      end
      ST_SYNC: begin
        if (accept) begin
          sof_n = 1'b0;
          acc_n = '0;
          cnt_n = '0;
`ifdef FRAME_SEQ_EN
          state_n = ST_SEQ;
          data_n  = seq;
`else
          state_n = ST_PAY;
          data_n  = head;
`endif
        end
      end
`ifdef FRAME_SEQ_EN
      ST_SEQ: begin
        if (accept) begin
          acc_n   = seq;
          state_n = ST_PAY;
          data_n  = head;
        end
      end
`endif
      ST_PAY: begin
        if (accept) begin
          pop   = ~empty;
          acc_n = sum_n;
          if (cnt == LAST) begin
            state_n = ST_CSUM;
            data_n  = csum_of(sum_n);
            eof_n   = 1'b1;
          end else begin
            cnt_n  = cnt + 1'b1;
            data_n = next_head;
          end
        end
      end
      ST_CSUM: begin
        if (accept) begin
          state_n = ST_IDLE;
          valid_n = 1'b0;
          data_n  = '0;
          eof_n   = 1'b0;
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_recovered_frame_builder.sv
// Directed bench for recovered_frame_builder (FRAME_LEN=4, DEPTH=8).
// Expectations follow FRAME_SEQ_EN when it is defined for the build.
module tb_recovered_frame_builder;

  logic       clk = 1'b0;
  logic       rst;
  logic       item_valid;
  logic [7:0] item_data;
  logic       frame_valid;
  logic       frame_ready;
  logic [7:0] frame_data;
  logic       frame_sof;
  logic       frame_eof;
  logic [7:0] drop_cnt;
  logic [3:0] fifo_level;

  int n_tests = 0;
  int n_fail  = 0;
  logic [7:0] exp_seq = 8'h00;

`ifdef FRAME_SEQ_EN
  localparam int SQ = 1;
`else
  localparam int SQ = 0;
`endif

  always #5 clk = ~clk;

  recovered_frame_builder #(
    .FRAME_LEN (4),
    .DEPTH     (8),
    .SYNC_BYTE (8'hA5)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .item_valid  (item_valid),
    .item_data   (item_data),
    .frame_valid (frame_valid),
    .frame_ready (frame_ready),
    .frame_data  (frame_data),
    .frame_sof   (frame_sof),
    .frame_eof   (frame_eof),
    .drop_cnt    (drop_cnt),
    .fifo_level  (fifo_level)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push1(input logic [7:0] v);
    item_valid = 1'b1;
    item_data  = v;
    step();
    item_valid = 1'b0;
  endtask

  task automatic push4(input logic [7:0] a, b, c, d);
    push1(a);
    push1(b);
    push1(c);
    push1(d);
  endtask

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_valid"}, 32'(frame_valid), 32'h0);
    chk({tag, "_data"},  32'(frame_data),  32'h0);
    chk({tag, "_sof"},   32'(frame_sof),   32'h0);
    chk({tag, "_eof"},   32'(frame_eof),   32'h0);
    chk({tag, "_level"}, 32'(fifo_level),  32'h0);
    chk({tag, "_drop"},  32'(drop_cnt),    32'h0);
  endtask

  // mode 0: ready held high; mode 1: ready 1,0,0,1 repeating.
  // abort_at >= 0 asserts rst while that byte index is presented.
  task automatic run_frame(input logic [7:0] p0, p1, p2, p3,
                           input int mode, input int abort_at);
    logic [7:0]  fb [8];
    logic [7:0]  sum;
    logic [10:0] held;
    int n, k, idx, cyc;
    bit stalled, aborted;
    fb[0] = 8'hA5;
    k = 1;
    sum = 8'h00;
    if (SQ == 1) begin
      fb[1] = exp_seq;
      sum   = exp_seq;
      k     = 2;
    end
    fb[k]   = p0;
    fb[k+1] = p1;
    fb[k+2] = p2;
    fb[k+3] = p3;
    sum = sum + p0 + p1 + p2 + p3;
    fb[k+4] = 8'h00 - sum;
    n = k + 5;
    idx = 0;
    cyc = 0;
    stalled = 0;
    aborted = 0;
    held = '0;
    while (idx < n && cyc < 200 && !aborted) begin
      frame_ready = (mode == 0) ? 1'b1 : (cyc % 4 == 0 || cyc % 4 == 3);
      if (stalled)
        chk("stall_hold", 32'({frame_valid, frame_sof, frame_eof, frame_data}),
            32'(held));
      stalled = 0;
      if (frame_valid && idx == abort_at) begin
        rst = 1'b1;
        #1;
        check_idle_outputs("abort");
        aborted = 1;
      end else begin
        if (frame_valid && frame_ready) begin
          chk("byte", 32'(frame_data), 32'(fb[idx]));
          chk("sof",  32'(frame_sof),  32'(idx == 0));
          chk("eof",  32'(frame_eof),  32'(idx == n - 1));
          idx++;
        end else if (frame_valid) begin
          stalled = 1;
          held = {frame_valid, frame_sof, frame_eof, frame_data};
        end
        step();
        cyc++;
      end
    end
    if (!aborted) begin
      chk("frame_done", 32'(idx), 32'(n));
      exp_seq = exp_seq + 8'd1;
    end
  endtask

  initial begin
    rst         = 1'b1;
    item_valid  = 1'b0;
    item_data   = 8'h00;
    frame_ready = 1'b0;
    repeat (3) step();
    check_idle_outputs("reset");
    rst = 1'b0;
    step();
    check_idle_outputs("post_reset");

    // Three items are not enough for a frame.
    push1(8'h01);
    push1(8'h02);
    push1(8'h03);
    frame_ready = 1'b1;
    repeat (3) step();
    chk("three_no_valid", 32'(frame_valid), 32'h0);
    chk("three_level", 32'(fifo_level), 32'h3);
    push1(8'h04);
    chk("fourth_level", 32'(fifo_level), 32'h4);
    chk("fourth_same_cycle", 32'(frame_valid), 32'h0);
    step();
    chk("fourth_valid", 32'(frame_valid), 32'h1);
    chk("fourth_sync", 32'(frame_data), 32'hA5);
    run_frame(8'h01, 8'h02, 8'h03, 8'h04, 0, -1);
    chk("frame1_level", 32'(fifo_level), 32'h0);

    // Same payload under toggling back-pressure.
    push4(8'h01, 8'h02, 8'h03, 8'h04);
    run_frame(8'h01, 8'h02, 8'h03, 8'h04, 1, -1);

    // Overflow with the sink stalled: last item is dropped.
    frame_ready = 1'b0;
    for (int i = 0; i < 9; i++) push1(8'(8'h10 + i));
    chk("ovf_level", 32'(fifo_level), 32'h8);
    chk("ovf_drop", 32'(drop_cnt), 32'h1);
    chk("ovf_stall_sof", 32'(frame_sof), 32'h1);
    run_frame(8'h10, 8'h11, 8'h12, 8'h13, 0, -1);
    run_frame(8'h14, 8'h15, 8'h16, 8'h17, 0, -1);
    chk("ovf_drained", 32'(fifo_level), 32'h0);

    // Drop counter saturation.
    frame_ready = 1'b0;
    for (int i = 0; i < 8; i++) push1(8'(8'h20 + i));
    item_valid = 1'b1;
    item_data  = 8'h99;
    repeat (260) step();
    item_valid = 1'b0;
    chk("sat_drop", 32'(drop_cnt), 32'hFF);
    chk("sat_level", 32'(fifo_level), 32'h8);

    // Reset while payload byte 2 is on the bus.
    run_frame(8'h20, 8'h21, 8'h22, 8'h23, 0, 2 + SQ);
    step();
    check_idle_outputs("abort_hold");
    rst = 1'b0;
    exp_seq = 8'h00;
    step();
    push4(8'h01, 8'h02, 8'h03, 8'h04);
    run_frame(8'h01, 8'h02, 8'h03, 8'h04, 0, -1);

`ifdef FRAME_SEQ_EN
    // Sequence wrap over 257 frames with varied payloads.
    rst = 1'b1;
    step();
    rst = 1'b0;
    exp_seq = 8'h00;
    step();
    for (int f = 0; f < 257; f++) begin
      logic [7:0] a, b, c, d;
      a = 8'($urandom);
      b = 8'($urandom);
      c = 8'($urandom);
      d = 8'($urandom);
      push4(a, b, c, d);
      run_frame(a, b, c, d, 0, -1);
    end
    chk("seq_wrapped", 32'(exp_seq), 32'h01);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
